// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams an instruction image byte-by-byte into a 32-bit
// instruction memory, MSB first, and stalls the pipeline while it loads.
// Ports:
//   Clk, Clr          clock, async active-low reset
//   start             one-cycle pulse, begins a load at byte address 0
//   in_valid/in_data  byte stream; in_last marks the final image byte
//   in_ready          loader accepts a byte this cycle
//   mem_we/mem_addr/mem_wdata  instruction memory word write port
//   busy              load in progress (stall PC / IF-ID)
//   done/error        image loaded / image overflowed memory (sticky to start)
//   word_count        words written in the current/last load
module instr_mem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [6:0]        word_count
);

  localparam int unsigned WordW = 32;
  localparam int unsigned CntW  = 7;
  // Byte address of the final word slot; writing here without in_last overflows.
  localparam logic [ADDR_W-1:0] LastWordAddr = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WordW-1:0]  wdata_q, wdata_d;
  logic [1:0]        idx_q, idx_d;
  logic              last_q, last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              in_ready_q, mem_we_q, busy_q, done_q, error_q;

  // State and datapath registers; status outputs are registered from next state.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == LOAD);
      mem_we_q   <= (state_d == WRITE);
      busy_q     <= (state_d == LOAD) || (state_d == WRITE);
      done_q     <= (state_d == DONE);
      error_q    <= (state_d == ERR);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          wdata_d = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          // Byte k lands in bits [31-8k -: 8], MSB first.
          unique case (idx_q)
            2'd0: wdata_d[31:24] = in_data;
            2'd1: wdata_d[23:16] = in_data;
            2'd2: wdata_d[15:8]  = in_data;
            2'd3: wdata_d[7:0]   = in_data;
            default: ;
          endcase
          idx_d = idx_q + 2'd1;
          if (in_last) last_d = 1'b1;
          if (in_last || idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + CntW'(1);
        if (last_q) begin
          state_d = DONE;
        end else if (addr_q == LastWordAddr) begin
          state_d = ERR;
        end else begin
          state_d = LOAD;
          addr_d  = addr_q + ADDR_W'(4);
          wdata_d = '0;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized/directed stimulus for instr_mem_loader with a
// byte-stream reference model checked every cycle, plus literal write checks.
module tb_instr_mem_loader;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MEMSIZE = 1 << ADDR_W;

  logic              Clk = 1'b0;
  logic              Clr = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready, mem_we, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [6:0]        word_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [39:0] wlog[$];
  logic [7:0]  img[0:299];
  bit          tog = 1'b0;

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Clr(Clr), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is a list of accepted bytes grouped into words.
  bit          m_active = 0, m_wr = 0, m_done = 0, m_err = 0, m_last = 0;
  int          m_addr = 0, m_count = 0, m_nbytes = 0;
  logic [31:0] m_word = '0;

  always @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      m_active = 0; m_wr = 0; m_done = 0; m_err = 0; m_last = 0;
      m_addr = 0; m_count = 0; m_nbytes = 0; m_word = '0;
    end else if (m_wr) begin
      m_wr = 0;
      m_count++;
      if (m_last) begin
        m_active = 0; m_done = 1;
      end else if (m_addr + 4 >= MEMSIZE) begin
        m_active = 0; m_err = 1;
      end else begin
        m_addr += 4; m_word = '0; m_nbytes = 0;
      end
    end else if (m_active) begin
      if (in_valid) begin
        m_word = m_word | (32'(in_data) << (24 - 8 * m_nbytes));
        m_nbytes++;
        if (in_last) m_last = 1;
        if (m_nbytes == 4 || in_last) m_wr = 1;
      end
    end else if (start) begin
      m_active = 1; m_done = 0; m_err = 0; m_last = 0;
      m_addr = 0; m_count = 0; m_nbytes = 0; m_word = '0;
    end
  end

  // Per-cycle comparison against the model; also logs every memory write.
  always @(negedge Clk) begin
    chk("in_ready",   64'(in_ready),   64'(m_active && !m_wr));
    chk("mem_we",     64'(mem_we),     64'(m_wr));
    chk("busy",       64'(busy),       64'(m_active));
    chk("done",       64'(done),       64'(m_done));
    chk("error",      64'(error),      64'(m_err));
    chk("word_count", 64'(word_count), 64'(m_count));
    chk("mem_addr",   64'(mem_addr),   64'(m_addr));
    if (m_wr || mem_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_word));
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge Clk); #2;
    start = 1'b0;
  endtask

  // Present one byte until accepted; mode 0 = always valid, 1 = toggle, 2 = random.
  task automatic push_byte(input logic [7:0] b, input logic last, input int mode);
    bit acc = 0;
    int waited = 0;
    while (!acc) begin
      if (mode == 0)      in_valid = 1'b1;
      else if (mode == 1) begin in_valid = tog; tog = ~tog; end
      else                in_valid = 1'($urandom_range(0, 1));
      in_data = b;
      in_last = last;
      @(negedge Clk);
      acc = in_valid && in_ready;
      @(posedge Clk); #2;
      waited++;
      if (waited > 40) begin
        chk("accept_timeout", 64'(waited), 64'(0));
        acc = 1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_img(input int n, input logic with_last, input int mode);
    for (int i = 0; i < n; i++) push_byte(img[i], with_last && (i == n - 1), mode);
  endtask

  task automatic settle();
    repeat (4) @(posedge Clk);
    #2;
  endtask

  initial begin
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    repeat (3) @(posedge Clk);
    #2 Clr = 1'b1;
    settle();
    chk("idle_after_rst", 64'({in_ready, busy, done, error}), 64'(0));

    // Two full words, last on byte 8.
    wlog.delete();
    img[0] = 8'hE3; img[1] = 8'hA0; img[2] = 8'h00; img[3] = 8'h01;
    img[4] = 8'hE2; img[5] = 8'h81; img[6] = 8'h10; img[7] = 8'h02;
    pulse_start();
    push_img(8, 1'b1, 0);
    settle();
    chk("t1_nwrites", 64'(wlog.size()), 64'(2));
    if (wlog.size() == 2) begin
      chk("t1_w0", 64'(wlog[0]), 64'({8'h00, 32'hE3A00001}));
      chk("t1_w1", 64'(wlog[1]), 64'({8'h04, 32'hE2811002}));
    end
    chk("t1_done", 64'({done, busy, word_count}), 64'({1'b1, 1'b0, 7'd2}));

    // Partial final word is zero padded.
    wlog.delete();
    for (int i = 0; i < 6; i++) img[i] = 8'((i + 1) * 8'h11);
    pulse_start();
    push_img(6, 1'b1, 0);
    settle();
    chk("t2_nwrites", 64'(wlog.size()), 64'(2));
    if (wlog.size() == 2) begin
      chk("t2_w0", 64'(wlog[0]), 64'({8'h00, 32'h11223344}));
      chk("t2_w1", 64'(wlog[1]), 64'({8'h04, 32'h55660000}));
    end
    chk("t2_done", 64'({done, word_count}), 64'({1'b1, 7'd2}));

    // Overflow: 256 bytes without last, then extra bytes must not be taken.
    wlog.delete();
    for (int i = 0; i < 300; i++) img[i] = 8'(i);
    pulse_start();
    push_img(256, 1'b0, 0);
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (8) @(posedge Clk);
    #2 in_valid = 1'b0;
    chk("t3_nwrites", 64'(wlog.size()), 64'(64));
    if (wlog.size() == 64) chk("t3_wlast", 64'(wlog[63]), 64'({8'hFC, 32'hFCFDFEFF}));
    chk("t3_err", 64'({error, done, in_ready, busy, word_count}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 7'd64}));

    // Toggled in_valid across one word, then a single-byte last word.
    wlog.delete();
    img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3; img[3] = 8'hD4; img[4] = 8'hE5;
    tog = 1'b1;
    pulse_start();
    push_img(5, 1'b1, 1);
    settle();
    chk("t4_nwrites", 64'(wlog.size()), 64'(2));
    if (wlog.size() == 2) begin
      chk("t4_w0", 64'(wlog[0]), 64'({8'h00, 32'hA1B2C3D4}));
      chk("t4_w1", 64'(wlog[1]), 64'({8'h04, 32'hE5000000}));
    end

    // Reset mid-word discards the partial word.
    wlog.delete();
    pulse_start();
    push_byte(8'h12, 1'b0, 0);
    push_byte(8'h34, 1'b0, 0);
    Clr = 1'b0;
    #1;
    chk("t5_rst_out", 64'({in_ready, mem_we, busy, done, error, word_count, mem_addr}), 64'(0));
    @(posedge Clk); #2 Clr = 1'b1;
    settle();
    chk("t5_no_write", 64'(wlog.size()), 64'(0));
    chk("t5_idle", 64'({in_ready, busy}), 64'(0));
    img[0] = 8'hDE; img[1] = 8'hAD; img[2] = 8'hBE; img[3] = 8'hEF;
    pulse_start();
    push_img(4, 1'b1, 0);
    settle();
    chk("t5_nwrites", 64'(wlog.size()), 64'(1));
    if (wlog.size() == 1) chk("t5_w0", 64'(wlog[0]), 64'({8'h00, 32'hDEADBEEF}));

    // start during LOAD is ignored.
    wlog.delete();
    for (int i = 0; i < 13; i++) img[i] = 8'(8'h40 + i);
    pulse_start();
    for (int i = 0; i < 13; i++) begin
      if (i == 5) pulse_start();
      push_byte(img[i], i == 12, 0);
    end
    settle();
    chk("t6_count", 64'({done, word_count}), 64'({1'b1, 7'd4}));
    chk("t6_nwrites", 64'(wlog.size()), 64'(4));
    if (wlog.size() == 4) chk("t6_w3", 64'(wlog[3]), 64'({8'h0C, 32'h4C000000}));

    // Randomized images with random valid patterns.
    for (int r = 0; r < 8; r++) begin
      int n, mode, nw;
      n = $urandom_range(1, 40);
      mode = $urandom_range(0, 2);
      nw = (n + 3) / 4;
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      wlog.delete();
      pulse_start();
      push_img(n, 1'b1, mode);
      settle();
      chk("rnd_done", 64'({done, error, word_count}), 64'({1'b1, 1'b0, 7'(nw)}));
      chk("rnd_nwrites", 64'(wlog.size()), 64'(nw));
      if (wlog.size() == nw) begin
        for (int w = 0; w < nw; w++) begin
          logic [31:0] ew;
          ew = '0;
          for (int k = 0; k < 4; k++)
            if (4 * w + k < n) ew[31 - 8 * k -: 8] = img[4 * w + k];
          chk("rnd_word", 64'(wlog[w]), 64'({8'(4 * w), ew}));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
- REQ-001: Parameter ADDR_W, default 8: byte-address width of instruction memory (256 bytes, 64 words).
- REQ-002: Clk  input  1  rising-edge clock.
- REQ-003: Clr  input  1  asynchronous active-low reset.
- REQ-004: start  input  1  one-cycle pulse that begins a load at byte address 0.
- REQ-005: in_valid  input  1  in_data/in_last valid this cycle.
- REQ-006: in_data  input  8  instruction byte, most-significant byte of each word first.
- REQ-007: in_last  input  1  marks the final byte of the image; qualified by in_valid.
- REQ-008: in_ready  output  1  loader accepts a byte this cycle.
- REQ-009: mem_we  output  1  instruction-memory write strobe.
- REQ-010: mem_addr  output  ADDR_W  word-aligned byte address of the write.
- REQ-011: mem_wdata  output  32  assembled instruction word.
- REQ-012: busy  output  1  load in progress; drives PC/IF-ID LE low (stall).
- REQ-013: done  output  1  image loaded; held until the next start.
- REQ-014: error  output  1  image exceeded memory; held until the next start.
- REQ-015: word_count  output  7  words written in the current/last load (0..64).

Function
- REQ-016: FSM states: IDLE, LOAD, WRITE, DONE, ERR.
- REQ-017: IDLE/DONE/ERR + start -> LOAD; clear addr, byte index, word_count, done, error; set busy.
- REQ-018: start is ignored in LOAD and WRITE.
- REQ-019: in_ready = 1 only in LOAD; a byte is accepted when in_valid && in_ready.
- REQ-020: Byte k (0..3) of a word goes to mem_wdata[31-8k : 24-8k]; unfilled bytes are 0.
- REQ-021: Accepting the 4th byte, or any byte with in_last=1, moves LOAD -> WRITE.
- REQ-022: WRITE lasts exactly one cycle: mem_we=1 with current mem_addr/mem_wdata; mem_we=0 in every other state.
- REQ-023: Latency: byte that completes a word accepted at edge N -> mem_we high in cycle N+1; throughput 4 bytes per 5 cycles minimum.
- REQ-024: After WRITE: word_count += 1; if in_last was seen -> DONE; else if mem_addr = 0xFC -> ERR; else mem_addr += 4, byte index = 0, -> LOAD.
- REQ-025: mem_addr never wraps; the ERR check replaces wrap-around.
- REQ-026: DONE: done=1, busy=0. ERR: error=1, busy=0. done and error are never both 1.
- REQ-027: in_valid without in_ready: no state change, byte not consumed.
- REQ-028: busy = 1 in LOAD and WRITE, 0 otherwise.
- REQ-029: in_ready, mem_we, busy, done, error are registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
- REQ-030: Clr low asynchronously forces IDLE; all outputs 0; mem_addr = 0; word_count = 0.
- REQ-031: Clr asserted mid-load discards the partial word; no mem_we is issued for it.
- REQ-032: After Clr deasserts, the loader stays in IDLE until start.

Verification
- REQ-033: Reset, start, 8 bytes E3 A0 00 01 E2 81 10 02, last on byte 8 -> writes (0x00, E3A00001) then (0x04, E2811002); done=1; word_count=2; busy=0.
- REQ-034: Start, then 6 bytes 11 22 33 44 55 66 with last on byte 6 -> second write (0x04, 55660000); done=1; word_count=2.
- REQ-035: Start, 260 bytes with no last -> 64 writes, last write at 0xFC; then error=1, done=0, word_count=64, in_ready=0.
- REQ-036: in_valid toggled 1-0-1-0 while loading one word -> only valid-and-ready cycles are consumed; word assembled correctly; mem_we exactly 1 cycle after the 4th accepted byte.
- REQ-037: Clr pulsed low after 2 bytes of a word -> outputs 0 immediately; no mem_we; a new start loads from 0x00.
- REQ-038: start pulsed during LOAD -> ignored; addresses continue sequentially; done after last with the correct word_count.
